blok_besleyici: RTL
===================

Name: blok_besleyici

Overview:
- Byte-stream to 128-bit block packer that feeds the block input side of aes_engine (blok / g_gecerli / hazir).
- Collects bytes from an upstream source (UART/DMA), packs 16 of them MSB-first into a block, and queues complete blocks in a small FIFO.
- Presents the FIFO head to the engine with a valid/ready handshake, so byte intake continues while the engine is busy.

Parameters:
- FIFO_DERINLIK, 2, number of 128-bit block slots; power of two, at least 2.
- SAYAC_GENISLIK, 32, width of the issued-block counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- bayt  input  8  incoming data byte.
- bayt_gecerli  input  1  bayt is valid this cycle.
- bayt_son  input  1  qualifies bayt as the last byte of the message.
- bayt_hazir  output  1  packer can accept a byte this cycle.
- blok  output  128  block to aes_engine; first byte received sits at [127:120].
- g_gecerli  output  1  blok is valid; connects to aes_engine g_gecerli.
- hazir  input  1  aes_engine ready; connects to aes_engine hazir.
- blok_son  output  1  the presented block is the final block of a message.
- doluluk  output  clog2(FIFO_DERINLIK)+1  number of occupied FIFO slots.
- blok_sayaci  output  SAYAC_GENISLIK  blocks accepted by the engine since reset.

Behaviour:
- Reset (asynchronous, active-high) clears all state:
  - byte index to 0, accumulator to 0, FIFO empty.
  - outputs: g_gecerli=0, blok=0, blok_son=0, doluluk=0, blok_sayaci=0, bayt_hazir=0.
  - bayt_hazir rises on the first clk edge after rst falls.
  - Reset mid-block discards the partial block and all queued blocks.
- Byte acceptance: a byte is accepted on a rising edge when bayt_gecerli && bayt_hazir.
  - Byte k (index 0..15) is written to accumulator bits [127-8k -: 8].
  - The index increments on each accepted byte.
- Block push happens on the edge that accepts byte 15, or on an accepted byte with bayt_son=1.
  - The completed block, with its son flag, is written to the FIFO tail.
  - The index returns to 0 and the accumulator clears.
  - Unfilled bytes of a short final block are 0x00 (see the optional feature).
- bayt_hazir = (doluluk < FIFO_DERINLIK) && state==TOPLA. This is combinational from registered state.
  - A pop in the current cycle does not raise bayt_hazir until the next cycle.
- Engine side:
  - g_gecerli = (doluluk != 0). blok and blok_son show the FIFO head.
  - A pop occurs on an edge where g_gecerli && hazir. blok_sayaci increments on that edge and wraps modulo 2^SAYAC_GENISLIK.
  - While g_gecerli && !hazir, blok and blok_son hold stable.
  - blok reads 0 when the FIFO is empty.
- Push and pop on the same edge: doluluk is unchanged. The FIFO pointers wrap modulo FIFO_DERINLIK.
- Latency:
  - A block pushed on edge N shows g_gecerli=1 after edge N if the FIFO was empty.
  - Back-to-back pops at one block per cycle are supported when hazir stays high.
- bayt_son=1 with bayt_gecerli=0 is ignored.
- State machine has two states:
  - TOPLA (collect): normal operation.
  - DOLGU: inserts a pad block; exists only with the optional feature.

Optional Feature:
- Macro: BLOK_DOLGU_EN (PKCS#7 padding).
- Defined:
  - A final block with n accepted bytes (1..15) is padded with (16-n) bytes of value (16-n). For example, n=13 gives three bytes of 0x03.
  - If bayt_son arrives on byte 15 (full block), that block is pushed with son=0. The state then moves to DOLGU.
  - DOLGU holds bayt_hazir=0 and pushes a block of sixteen 0x10 bytes with son=1 as soon as the FIFO has space, then returns to TOPLA.
  - Reset in DOLGU returns to TOPLA without pushing.
- Undefined:
  - Short blocks are zero-filled and pushed with son=1.
  - A full block ending with bayt_son is pushed with son=1.
  - DOLGU is never entered.

Test Plan:
- Fill and issue: 16 bytes 71 77 65 72 74 79 75 69 6f 70 61 73 64 66 67 68 with hazir=1 -> one cycle after the 16th accept, g_gecerli=1 and blok=128'h71776572747975696f70617364666768. The pop follows, blok_sayaci=1.
- Back-pressure: hold hazir=0 and stream 48 bytes -> bayt_hazir drops after 32 bytes with doluluk=2 and blok stable. Raise hazir -> two pops on consecutive edges, bayt_hazir returns, blok_sayaci=2.
- Short last block, macro off: bytes 01 02 03 with bayt_son on 03 -> blok=128'h01020300000000000000000000000000, blok_son=1.
- Short last block, BLOK_DOLGU_EN: same stimulus -> blok=128'h0102030d0d0d0d0d0d0d0d0d0d0d0d0d, blok_son=1. For a full 16-byte message ending with bayt_son -> data block with son=0, then 16×0x10 with son=1.
- Simultaneous push/pop: FIFO at 1, 16th byte accepted on the same edge as a pop -> doluluk stays 1 and the new block is presented next.
- Reset mid-operation: assert rst after 7 bytes with one block queued -> g_gecerli=0 and doluluk=0 immediately. After release, 16 new bytes produce exactly one block containing only the new bytes.

Source files
------------

// File: rtl/blok_besleyici.sv
// Packs a byte stream MSB-first into 128-bit blocks and queues them for aes_engine.
// A block shows one cycle after its last byte. The FIFO absorbs engine stalls, and bayt_hazir drops when the FIFO is full. BLOK_DOLGU_EN selects PKCS#7 padding.
module blok_besleyici #(
   parameter int FIFO_DERINLIK  = 2,
   parameter int SAYAC_GENISLIK = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [7:0]                         bayt,
   input  logic                               bayt_gecerli,
   input  logic                               bayt_son,
   output logic                               bayt_hazir,
   output logic [127:0]                       blok,
   output logic                               g_gecerli,
   input  logic                               hazir,
   output logic                               blok_son,
   output logic [$clog2(FIFO_DERINLIK):0]     doluluk,
   output logic [SAYAC_GENISLIK-1:0]          blok_sayaci
);
   localparam int PW = $clog2(FIFO_DERINLIK);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DOLU = CW'(FIFO_DERINLIK);

   typedef enum logic {TOPLA = 1'b0, DOLGU = 1'b1} durum_t;

   durum_t                    durum_q, durum_d;
   logic                      basla_q;
   logic [3:0]                idx_q, idx_d;
   logic [127:0]              acc_q, acc_d;
   logic [127:0]              mem_q [FIFO_DERINLIK];
   logic [FIFO_DERINLIK-1:0]  son_mem_q;
   logic [PW-1:0]             wr_q, rd_q;
   logic [CW-1:0]             dol_q;
   logic [SAYAC_GENISLIK-1:0] sayac_q;
   logic                      kabul, push, pop, push_son;
   logic [127:0]              yeni_acc, push_blok;

   assign bayt_hazir  = basla_q && (durum_q == TOPLA) && (dol_q < DOLU);
   assign g_gecerli   = (dol_q != '0);
   assign blok        = g_gecerli ? mem_q[rd_q] : '0;
   assign blok_son    = g_gecerli && son_mem_q[rd_q];
   assign doluluk     = dol_q;
   assign blok_sayaci = sayac_q;
   assign kabul       = bayt_gecerli && bayt_hazir;
   assign pop         = g_gecerli && hazir;

   always_comb begin
      yeni_acc = acc_q;
      yeni_acc[8*(15-int'(idx_q)) +: 8] = bayt;
      push      = 1'b0;
      push_blok = yeni_acc;
      push_son  = bayt_son;
      idx_d     = idx_q;
      acc_d     = acc_q;
      durum_d   = durum_q;
      if (kabul) begin
         if (idx_q == 4'd15 || bayt_son) begin
            push  = 1'b1;
            idx_d = 4'd0;
            acc_d = '0;
`ifdef BLOK_DOLGU_EN
            if (idx_q == 4'd15) begin
               // A message ending on a block boundary still needs a full pad block.
               push_son = 1'b0;
               if (bayt_son) durum_d = DOLGU;
            end else begin
               for (int k = 0; k < 16; k++)
                  if (k > int'(idx_q)) push_blok[8*(15-k) +: 8] = 8'(15 - int'(idx_q));
            end
`endif
         end else begin
            idx_d = idx_q + 4'd1;
            acc_d = yeni_acc;
         end
      end
`ifdef BLOK_DOLGU_EN
      if (durum_q == DOLGU && dol_q < DOLU) begin
         push      = 1'b1;
         push_blok = {16{8'h10}};
         push_son  = 1'b1;
         durum_d   = TOPLA;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         durum_q   <= TOPLA;
         basla_q   <= 1'b0;
         idx_q     <= 4'd0;
         acc_q     <= '0;
         for (int i = 0; i < FIFO_DERINLIK; i++) mem_q[i] <= '0;
         son_mem_q <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         dol_q     <= '0;
         sayac_q   <= '0;
      end else begin
         basla_q <= 1'b1;
         durum_q <= durum_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         if (push) begin
            mem_q[wr_q]     <= push_blok;
            son_mem_q[wr_q] <= push_son;
            wr_q            <= wr_q + 1'b1;
         end
         if (pop) begin
            rd_q    <= rd_q + 1'b1;
            sayac_q <= sayac_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   dol_q <= dol_q + 1'b1;
            2'b01:   dol_q <= dol_q - 1'b1;
            default: dol_q <= dol_q;
         endcase
      end
   end
endmodule
